// File: rtl/miter_stream_checker.sv
// -----------------------------------------------------------------------------
// miter_stream_checker
//
// Purpose:
//   Streaming equivalence checker. A gold (reference) stream with per-bit
//   don't-care mask is delayed by ALIGN cycles and compared channel by channel
//   against an implementation (gate) stream. A small run-control FSM counts
//   compares and mismatching compares, and latches the channel mismatch
//   vector of the first failing compare.
//
// Optional feature:
//   MITER_CAPTURE_EN - when defined, adds cap_gold / cap_gate / cap_cycle, which
//   hold the aligned gold word, the gate word and the 0-based compare index of
//   the first failing compare.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   start      pulse: clear counters, flush delay line, enter RUN
//   stop       pulse: end the run (RUN -> DONE)
//   in_valid   gold / gold_dc / gate valid this cycle
//   gold       reference word, channel c at [c*WIDTH +: WIDTH]
//   gold_dc    per-bit don't-care for gold (1 = excluded from compare)
//   gate       implementation word, compared undelayed
//   state      0=IDLE 1=RUN 2=FAIL 3=DONE
//   fail       high while in FAIL
//   fail_chan  channel mismatch vector of the first failing compare
//   cmp_count  compares performed in this run (saturating)
//   mis_count  compares with at least one mismatching channel (saturating)
// -----------------------------------------------------------------------------
module miter_stream_checker #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 1,
   parameter int ALIGN    = 1,
   parameter int CNT_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic                        in_valid,
   input  logic [CHANNELS*WIDTH-1:0]   gold,
   input  logic [CHANNELS*WIDTH-1:0]   gold_dc,
   input  logic [CHANNELS*WIDTH-1:0]   gate,
   output logic [1:0]                  state,
   output logic                        fail,
   output logic [CHANNELS-1:0]         fail_chan,
   output logic [CNT_W-1:0]            cmp_count,
   output logic [CNT_W-1:0]            mis_count
`ifdef MITER_CAPTURE_EN
   ,
   output logic [CHANNELS*WIDTH-1:0]   cap_gold,
   output logic [CHANNELS*WIDTH-1:0]   cap_gate,
   output logic [CNT_W-1:0]            cap_cycle
`endif
);

   localparam int DW = CHANNELS * WIDTH;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FAIL = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Aligned (delayed) gold path
   logic          al_valid;
   logic [DW-1:0] al_gold;
   logic [DW-1:0] al_dc;

   genvar gi;

   generate
      if (ALIGN == 0) begin : g_no_delay
         assign al_valid = in_valid;
         assign al_gold  = gold;
         assign al_dc    = gold_dc;
      end else begin : g_delay
         logic [ALIGN-1:0]          dv_q, dv_d;
         logic [ALIGN-1:0][DW-1:0]  dg_q, dg_d;
         logic [ALIGN-1:0][DW-1:0]  dd_q, dd_d;

         // Valid bits are cleared on start so beats presented before or
         // during the start cycle never reach the comparator.
         for (gi = 0; gi < ALIGN; gi++) begin : g_stage
            if (gi == 0) begin : g_first
               assign dv_d[gi] = in_valid & ~start;
               assign dg_d[gi] = gold;
               assign dd_d[gi] = gold_dc;
            end else begin : g_next
               assign dv_d[gi] = dv_q[gi-1] & ~start;
               assign dg_d[gi] = dg_q[gi-1];
               assign dd_d[gi] = dd_q[gi-1];
            end
         end

         // Only the valid bits need a reset; data is qualified by them.
         always_ff @(posedge clk) begin
            if (rst) begin
               dv_q <= '0;
            end else begin
               dv_q <= dv_d;
            end
            dg_q <= dg_d;
            dd_q <= dd_d;
         end

         assign al_valid = dv_q[ALIGN-1];
         assign al_gold  = dg_q[ALIGN-1];
         assign al_dc    = dd_q[ALIGN-1];
      end
   endgenerate

   // Per-channel mismatch: any cared-about bit differing
   logic [CHANNELS-1:0] chan_mis;

   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign chan_mis[gi] = |((al_gold[gi*WIDTH +: WIDTH] ^ gate[gi*WIDTH +: WIDTH])
                                 & ~al_dc[gi*WIDTH +: WIDTH]);
      end
   endgenerate

   // Run-control state
   logic [1:0]          state_q, state_d;
   logic [CHANNELS-1:0] fail_chan_q, fail_chan_d;
   logic [CNT_W-1:0]    cmp_count_q, cmp_count_d;
   logic [CNT_W-1:0]    mis_count_q, mis_count_d;

   logic cmp_en;
   logic cmp_bad;
   logic first_fail;

   // Compares keep running in FAIL so the counters show the full picture.
   assign cmp_en     = al_valid && ((state_q == ST_RUN) || (state_q == ST_FAIL));
   assign cmp_bad    = cmp_en && (|chan_mis);
   assign first_fail = !start && cmp_bad && (state_q == ST_RUN);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   always_comb begin
      state_d     = state_q;
      fail_chan_d = fail_chan_q;
      cmp_count_d = cmp_count_q;
      mis_count_d = mis_count_q;

      if (start) begin
         // start wins over stop and over any compare this cycle
         state_d     = ST_RUN;
         fail_chan_d = '0;
         cmp_count_d = '0;
         mis_count_d = '0;
      end else begin
         if (cmp_en) begin
            cmp_count_d = sat_inc(cmp_count_q);
         end
         if (cmp_bad) begin
            mis_count_d = sat_inc(mis_count_q);
         end
         if (state_q == ST_RUN) begin
            // a mismatch in the same cycle as stop still reports FAIL
            if (cmp_bad) begin
               state_d     = ST_FAIL;
               fail_chan_d = chan_mis;
            end else if (stop) begin
               state_d = ST_DONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         fail_chan_q <= '0;
         cmp_count_q <= '0;
         mis_count_q <= '0;
      end else begin
         state_q     <= state_d;
         fail_chan_q <= fail_chan_d;
         cmp_count_q <= cmp_count_d;
         mis_count_q <= mis_count_d;
      end
   end

   assign state     = state_q;
   assign fail      = (state_q == ST_FAIL);
   assign fail_chan = fail_chan_q;
   assign cmp_count = cmp_count_q;
   assign mis_count = mis_count_q;

`ifdef MITER_CAPTURE_EN
   logic [DW-1:0]    cap_gold_q, cap_gold_d;
   logic [DW-1:0]    cap_gate_q, cap_gate_d;
   logic [CNT_W-1:0] cap_cycle_q, cap_cycle_d;

   always_comb begin
      cap_gold_d  = cap_gold_q;
      cap_gate_d  = cap_gate_q;
      cap_cycle_d = cap_cycle_q;
      if (start) begin
         cap_gold_d  = '0;
         cap_gate_d  = '0;
         cap_cycle_d = '0;
      end else if (first_fail) begin
         // cmp_count before increment is the 0-based index of this compare
         cap_gold_d  = al_gold;
         cap_gate_d  = gate;
         cap_cycle_d = cmp_count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_gold_q  <= '0;
         cap_gate_q  <= '0;
         cap_cycle_q <= '0;
      end else begin
         cap_gold_q  <= cap_gold_d;
         cap_gate_q  <= cap_gate_d;
         cap_cycle_q <= cap_cycle_d;
      end
   end

   assign cap_gold  = cap_gold_q;
   assign cap_gate  = cap_gate_q;
   assign cap_cycle = cap_cycle_q;
`else
   // first_fail only drives the capture registers
   logic unused_first_fail;
   assign unused_first_fail = first_fail;
`endif

endmodule

// File: doc/miter_stream_checker.md
MITER_STREAM_CHECKER -- requirements
Module: miter_stream_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bits per channel.
REQ-002 SHALL have parameter CHANNELS, default 1: number of compared channels (1..32).
REQ-003 SHALL have parameter ALIGN, default 1: gold-path delay in cycles (0..15).
REQ-004 SHALL have parameter CNT_W, default 16: width of the cycle and mismatch counters.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  single-cycle pulse; clears the counters and enters RUN.
REQ-009 stop  in  1  single-cycle pulse; ends the run.
REQ-010 in_valid  in  1  gold, gold_dc and gate are valid this cycle.
REQ-011 gold  in  CHANNELS*WIDTH  reference outputs; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 gold_dc  in  CHANNELS*WIDTH  per-bit don't-care (1 = gold bit undefined, so the bit is excluded from compare).
REQ-013 gate  in  CHANNELS*WIDTH  implementation outputs, compared without delay.
REQ-014 state  out  2  0=IDLE, 1=RUN, 2=FAIL, 3=DONE.
REQ-015 fail  out  1  high while state==FAIL.
REQ-016 fail_chan  out  CHANNELS  channel mismatch vector of the first failing compare.
REQ-017 cmp_count  out  CNT_W  compares performed in the current run.
REQ-018 mis_count  out  CNT_W  compares with at least one mismatching channel.

Function
REQ-019 Gold path: gold, gold_dc and in_valid SHALL pass through an ALIGN-stage register delay line; with ALIGN=0 the path is a wire.
REQ-020 A compare occurs when the delayed valid is high in RUN; channel c mismatches if any bit has gold_dc=0 and gold != gate.
REQ-021 The compare result SHALL be registered: state, counters and fail_chan update one cycle after the compare cycle.
REQ-022 FSM IDLE->RUN on start; RUN->FAIL on the first mismatching compare; RUN->DONE on stop; FAIL or DONE->RUN on start; a start in RUN restarts the run (counters cleared, RUN kept).
REQ-023 In RUN, a mismatch and stop in the same cycle SHALL go to FAIL.
REQ-024 start together with stop SHALL give start priority.
REQ-025 In FAIL, compares SHALL continue: cmp_count and mis_count keep counting; fail_chan is held at the first failure.
REQ-026 In IDLE and DONE, no compares occur and the counters hold.
REQ-027 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 The delay line SHALL be flushed (valid bits cleared) on start, so no pre-start data is compared.

Reset
REQ-029 rst SHALL take priority over all inputs.
REQ-030 rst SHALL force: state=IDLE, fail=0, fail_chan=0, cmp_count=0, mis_count=0, delay-line valid bits=0.
REQ-031 A reset asserted mid-run SHALL abort the run with no residual compare in the following cycle.

Configuration
REQ-032 Macro MITER_CAPTURE_EN SHALL, when defined, add outputs cap_gold and cap_gate (each CHANNELS*WIDTH) holding the aligned gold and gate words of the first failing compare, and a CNT_W-bit cap_cycle equal to the cmp_count value at that compare (0-based); all three reset to 0.
REQ-033 Without MITER_CAPTURE_EN, these ports and their registers SHALL be absent; all other behaviour is identical.

Verification
REQ-034 WIDTH=4, CHANNELS=2, ALIGN=1: start, 5 valid beats with gate = gold delayed 1 cycle, then stop -> state RUN then DONE, cmp_count=5, mis_count=0, fail=0.
REQ-035 Same configuration, beat 3 ch1 gate=4'hA against gold=4'hB -> state=FAIL one cycle after the compare, fail_chan=2'b10, mis_count=1; with MITER_CAPTURE_EN, cap_cycle=2.
REQ-036 Same mismatch with gold_dc ch1 = 4'hF -> no failure, mis_count=0.
REQ-037 CNT_W=3: 10 matching beats -> cmp_count saturates at 7.
REQ-038 Mismatch and stop in the same cycle -> FAIL; next start -> RUN, counters=0, fail_chan=0.
REQ-039 rst pulse mid-run with valid data in the delay line -> IDLE, all outputs 0, and no compare after release until start.
